// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: AXI4 channel widths, encodings and request/response structs
// shared by axi_mem_responder and its users.
package axi_mem_pkg;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned IdWidth   = 4;

    localparam logic [1:0] BurstFixed = 2'd0;
    localparam logic [1:0] BurstIncr  = 2'd1;
    localparam logic [1:0] BurstWrap  = 2'd2;
    localparam logic [1:0] RespOkay   = 2'd0;
    localparam logic [1:0] RespSlvErr = 2'd2;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } ax_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;
endpackage

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 subordinate backed by a word-addressed memory array,
// with independent single-outstanding read and write FSMs.
module axi_mem_responder #(
    parameter type axi_req_t = axi_mem_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_mem_pkg::axi_rsp_t,
    parameter int unsigned NumWords = 1024,
    parameter logic [axi_mem_pkg::AddrWidth-1:0] BaseAddr = 64'h8000_0000
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_resp_o
);
    import axi_mem_pkg::*;

    localparam int NB  = DataWidth / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = $clog2(NumWords);
    localparam logic [AddrWidth-1:0] EndAddr = BaseAddr + AddrWidth'(NumWords * NB);

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    r_state_t             r_state;
    w_state_t             w_state;
    logic [IdWidth-1:0]   r_id, w_id;
    logic [AddrWidth-1:0] r_addr, w_addr;
    logic [7:0]           r_len, w_len, r_cnt, w_cnt;
    logic [2:0]           r_size, w_size;
    logic [1:0]           r_burst, w_burst;
    logic                 w_err, r_ok, w_ok;
    logic [IW-1:0]        r_word, w_word;
    logic [DataWidth-1:0] mem [NumWords];

    function automatic logic in_range(input logic [AddrWidth-1:0] a);
        return a >= BaseAddr && a < EndAddr;
    endfunction

    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
        logic [AddrWidth-1:0] step;
        step = AddrWidth'(1) << size;
        return burst == BurstFixed ? a : (a & ~(step - 1)) + step;
    endfunction

    assign r_word = r_addr[OFF +: IW];
    assign w_word = w_addr[OFF +: IW];
    assign r_ok   = in_range(r_addr) && r_burst != BurstWrap;
    assign w_ok   = in_range(w_addr) && w_burst != BurstWrap;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else if (r_state == R_IDLE) begin
            if (axi_req_i.ar_valid) begin
                r_state <= R_DATA;
                r_id    <= axi_req_i.ar.id;
                r_addr  <= axi_req_i.ar.addr;
                r_len   <= axi_req_i.ar.len;
                r_size  <= axi_req_i.ar.size;
                r_burst <= axi_req_i.ar.burst;
                r_cnt   <= '0;
            end
        end else if (axi_req_i.r_ready) begin
            r_addr <= next_addr(r_addr, r_size, r_burst);
            r_cnt  <= r_cnt + 8'd1;
            if (r_cnt == r_len) r_state <= R_IDLE;
        end
    end

    // Only w.last closes a write burst; a length mismatch is reported, not enforced.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (axi_req_i.aw_valid) begin
                    w_state <= W_DATA;
                    w_id    <= axi_req_i.aw.id;
                    w_addr  <= axi_req_i.aw.addr;
                    w_len   <= axi_req_i.aw.len;
                    w_size  <= axi_req_i.aw.size;
                    w_burst <= axi_req_i.aw.burst;
                    w_cnt   <= '0;
                    w_err   <= 1'b0;
                end
                W_DATA: if (axi_req_i.w_valid) begin
                    w_addr <= next_addr(w_addr, w_size, w_burst);
                    w_cnt  <= w_cnt + 8'd1;
                    if (!w_ok || axi_req_i.w.last != (w_cnt == w_len)) w_err <= 1'b1;
                    if (axi_req_i.w.last) w_state <= W_RESP;
                end
                default: if (axi_req_i.b_ready) w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_state == W_DATA && axi_req_i.w_valid && w_ok)
            for (int i = 0; i < NB; i++)
                if (axi_req_i.w.strb[i]) mem[w_word][8*i +: 8] <= axi_req_i.w.data[8*i +: 8];
    end

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.ar_ready = r_state == R_IDLE;
        axi_resp_o.aw_ready = w_state == W_IDLE;
        axi_resp_o.w_ready  = w_state == W_DATA;
        axi_resp_o.r_valid  = r_state == R_DATA;
        axi_resp_o.b_valid  = w_state == W_RESP;
        if (r_state == R_DATA) begin
            axi_resp_o.r.id   = r_id;
            axi_resp_o.r.data = r_ok ? mem[r_word] : '0;
            axi_resp_o.r.resp = r_ok ? RespOkay : RespSlvErr;
            axi_resp_o.r.last = r_cnt == r_len;
        end
        if (w_state == W_RESP) begin
            axi_resp_o.b.id   = w_id;
            axi_resp_o.b.resp = w_err ? RespSlvErr : RespOkay;
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed table of single-beat write/read pairs plus
// hand-written burst, error, concurrency and reset sequences.
module tb_axi_mem_responder;
    import axi_mem_pkg::*;

    logic     clk = 1'b0;
    logic     rst_ni = 1'b0;
    axi_req_t req;
    axi_rsp_t rsp;
    int       total = 0;
    int       bad = 0;
    logic [63:0] wbuf [8];
    logic [63:0] ebuf [8];

    typedef struct {
        bit          wr;
        logic [3:0]  wid;
        logic [3:0]  rid;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  bresp;
        logic [63:0] rdata;
        logic [1:0]  rresp;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    axi_mem_responder dut (.clk_i(clk), .rst_ni(rst_ni), .axi_req_i(req), .axi_resp_o(rsp));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int k);
        return k == 0 ? rsp.aw_ready : k == 1 ? rsp.w_ready : k == 2 ? rsp.ar_ready : rsp.b_valid;
    endfunction

    task automatic wait_for(input int k, input string name);
        int n = 0;
        while (!sig(k) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!sig(k)) begin
            total++;
            bad++;
            $display("FAIL %s: timeout after %0d cycles", name, n);
        end
    endtask

    task automatic write_tx(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int nbeats, input logic [7:0] strb,
                            input logic [1:0] exp_resp);
        @(negedge clk);
        req.aw = '{id: id, addr: addr, len: len, size: 3'd3, burst: burst};
        req.aw_valid = 1'b1;
        wait_for(0, "aw_ready");
        @(negedge clk);
        req.aw_valid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            req.w = '{data: wbuf[i], strb: strb, last: (i == nbeats - 1)};
            req.w_valid = 1'b1;
            wait_for(1, "w_ready");
            @(negedge clk);
        end
        req.w_valid = 1'b0;
        chk("b_valid latency", 64'(rsp.b_valid), 64'd1);
        chk("b id", 64'(rsp.b.id), 64'(id));
        chk("b resp", 64'(rsp.b.resp), 64'(exp_resp));
        req.b_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
        chk("aw_ready after b", 64'(rsp.aw_ready), 64'd1);
    endtask

    task automatic read_tx(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit stall, input logic [1:0] exp_resp);
        logic [63:0] held;
        @(negedge clk);
        req.ar = '{id: id, addr: addr, len: len, size: 3'd3, burst: burst};
        req.ar_valid = 1'b1;
        wait_for(2, "ar_ready");
        @(negedge clk);
        req.ar_valid = 1'b0;
        chk("ar_ready busy", 64'(rsp.ar_ready), 64'd0);
        for (int i = 0; i <= int'(len); i++) begin
            if (stall) begin
                req.r_ready = 1'b0;
                held = rsp.r.data;
                @(negedge clk);
                chk("r data held", rsp.r.data, held);
                chk("r last held", 64'(rsp.r.last), 64'(i == int'(len)));
            end
            chk("r_valid", 64'(rsp.r_valid), 64'd1);
            chk("r id", 64'(rsp.r.id), 64'(id));
            chk("r data", rsp.r.data, ebuf[i]);
            chk("r resp", 64'(rsp.r.resp), 64'(exp_resp));
            chk("r last", 64'(rsp.r.last), 64'(i == int'(len)));
            req.r_ready = 1'b1;
            @(negedge clk);
            req.r_ready = 1'b0;
        end
        chk("ar_ready after r", 64'(rsp.ar_ready), 64'd1);
        chk("r_valid after r", 64'(rsp.r_valid), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{1, 4'b0111, 4'b1000, 64'h8000_0010, 64'hDEADBEEF_CAFEF00D, 8'hFF, RespOkay, 64'hDEADBEEF_CAFEF00D, RespOkay};
        tbl[1]  = '{1, 4'b0000, 4'b0000, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, RespOkay, 64'h0123_4567_89AB_CDEF, RespOkay};
        tbl[2]  = '{1, 4'b0111, 4'b0000, 64'h8000_0040, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, RespOkay, 64'hFFFF_FFFF_FFFF_FFFF, RespOkay};
        tbl[3]  = '{1, 4'b0111, 4'b0000, 64'h8000_0040, 64'h1122_3344_5566_7788, 8'h0F, RespOkay, 64'hFFFF_FFFF_5566_7788, RespOkay};
        tbl[4]  = '{1, 4'b1010, 4'b1010, 64'h8000_0040, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00, RespOkay, 64'hFFFF_FFFF_5566_7788, RespOkay};
        tbl[5]  = '{1, 4'b0111, 4'b1111, 64'h8000_0040, 64'h0102_0304_0506_0708, 8'hF0, RespOkay, 64'h0102_0304_5566_7788, RespOkay};
        tbl[6]  = '{1, 4'b0111, 4'b0111, 64'h8000_1FF8, 64'h5A5A, 8'hFF, RespOkay, 64'h5A5A, RespOkay};
        tbl[7]  = '{1, 4'b0111, 4'b1000, 64'h8000_2000, 64'h1, 8'hFF, RespSlvErr, 64'h0, RespSlvErr};
        tbl[8]  = '{1, 4'b0111, 4'b1000, 64'h7FFF_FFF8, 64'h99, 8'hFF, RespSlvErr, 64'h0, RespSlvErr};
        tbl[9]  = '{0, 4'b0000, 4'b0000, 64'h8000_0000, 64'h0, 8'h00, RespOkay, 64'h0123_4567_89AB_CDEF, RespOkay};
        tbl[10] = '{0, 4'b0000, 4'b1000, 64'h8000_1FF8, 64'h0, 8'h00, RespOkay, 64'h5A5A, RespOkay};

        req = '0;
        #1;
        chk("reset ar_ready", 64'(rsp.ar_ready), 64'd1);
        chk("reset aw_ready", 64'(rsp.aw_ready), 64'd1);
        chk("reset w_ready", 64'(rsp.w_ready), 64'd0);
        chk("reset r_valid", 64'(rsp.r_valid), 64'd0);
        chk("reset b_valid", 64'(rsp.b_valid), 64'd0);
        chk("reset r data", rsp.r.data, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                wbuf[0] = tbl[i].data;
                write_tx(tbl[i].wid, tbl[i].addr, 8'd0, BurstIncr, 1, tbl[i].strb, tbl[i].bresp);
            end
            ebuf[0] = tbl[i].rdata;
            read_tx(tbl[i].rid, tbl[i].addr, 8'd0, BurstIncr, 1'b0, tbl[i].rresp);
        end

        // INCR burst with stalled read-back, then FIXED re-reads of the first word
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 64'(i + 1);
            ebuf[i] = 64'(i + 1);
        end
        write_tx(4'b0111, 64'h8000_0100, 8'd3, BurstIncr, 4, 8'hFF, RespOkay);
        read_tx(4'b0000, 64'h8000_0100, 8'd3, BurstIncr, 1'b1, RespOkay);
        ebuf[1] = 64'd1;
        read_tx(4'b0000, 64'h8000_0100, 8'd1, BurstFixed, 1'b0, RespOkay);

        // WRAP is rejected as a whole and leaves the array untouched
        wbuf[0] = 64'h77;
        write_tx(4'b0111, 64'h8000_0200, 8'd0, BurstIncr, 1, 8'hFF, RespOkay);
        wbuf[0] = 64'h55;
        wbuf[1] = 64'h66;
        write_tx(4'b0111, 64'h8000_0200, 8'd1, BurstWrap, 2, 8'hFF, RespSlvErr);
        ebuf[0] = 64'h0;
        ebuf[1] = 64'h0;
        read_tx(4'b1000, 64'h8000_0200, 8'd1, BurstWrap, 1'b0, RespSlvErr);
        ebuf[0] = 64'h77;
        read_tx(4'b1000, 64'h8000_0200, 8'd0, BurstIncr, 1'b0, RespOkay);

        // early w.last on a len=3 burst
        write_tx(4'b0111, 64'h8000_0300, 8'd3, BurstIncr, 3, 8'hFF, RespSlvErr);

        // AR and AW accepted together on the same word: read sees old data
        wbuf[0] = 64'hA;
        write_tx(4'b0111, 64'h8000_0020, 8'd0, BurstIncr, 1, 8'hFF, RespOkay);
        @(negedge clk);
        req.ar = '{id: 4'b1000, addr: 64'h8000_0020, len: 8'd0, size: 3'd3, burst: BurstIncr};
        req.aw = '{id: 4'b0111, addr: 64'h8000_0020, len: 8'd0, size: 3'd3, burst: BurstIncr};
        req.ar_valid = 1'b1;
        req.aw_valid = 1'b1;
        chk("conc ar_ready", 64'(rsp.ar_ready), 64'd1);
        chk("conc aw_ready", 64'(rsp.aw_ready), 64'd1);
        @(negedge clk);
        req.ar_valid = 1'b0;
        req.aw_valid = 1'b0;
        req.w = '{data: 64'hB, strb: 8'hFF, last: 1'b1};
        req.w_valid = 1'b1;
        req.r_ready = 1'b1;
        chk("conc w_ready", 64'(rsp.w_ready), 64'd1);
        chk("conc r_valid", 64'(rsp.r_valid), 64'd1);
        chk("conc r old data", rsp.r.data, 64'hA);
        @(negedge clk);
        req.w_valid = 1'b0;
        req.r_ready = 1'b0;
        chk("conc b_valid", 64'(rsp.b_valid), 64'd1);
        chk("conc b resp", 64'(rsp.b.resp), 64'(RespOkay));
        chk("conc r done", 64'(rsp.r_valid), 64'd0);
        req.b_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
        ebuf[0] = 64'hB;
        read_tx(4'b0000, 64'h8000_0020, 8'd0, BurstIncr, 1'b0, RespOkay);

        // asynchronous reset in the middle of a stalled read burst
        @(negedge clk);
        req.ar = '{id: 4'b0000, addr: 64'h8000_0100, len: 8'd3, size: 3'd3, burst: BurstIncr};
        req.ar_valid = 1'b1;
        wait_for(2, "ar_ready");
        @(negedge clk);
        req.ar_valid = 1'b0;
        chk("mid r_valid", 64'(rsp.r_valid), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("abort r_valid", 64'(rsp.r_valid), 64'd0);
        chk("abort ar_ready", 64'(rsp.ar_ready), 64'd1);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("post reset r_valid", 64'(rsp.r_valid), 64'd0);
        ebuf[0] = 64'h1;
        read_tx(4'b0000, 64'h8000_0100, 8'd0, BurstIncr, 1'b0, RespOkay);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
